// File: rtl/ls_pkg.sv
// rtl/ls_pkg.sv - load/store opcode encodings, byte-enable constants and store queue entry type
package ls_pkg;

    // Memory-stage load/store opcodes; the load extension unit uses the same encodings
    localparam logic [3:0] LS_NONE = 4'b0000;
    localparam logic [3:0] LS_LW   = 4'b0001;
    localparam logic [3:0] LS_LH   = 4'b0010;
    localparam logic [3:0] LS_LHU  = 4'b0011;
    localparam logic [3:0] LS_LB   = 4'b0100;
    localparam logic [3:0] LS_LBU  = 4'b0101;
    localparam logic [3:0] LS_SW   = 4'b0110;
    localparam logic [3:0] LS_SH   = 4'b0111;
    localparam logic [3:0] LS_SB   = 4'b1000;

    // Byte-enable patterns; a byte store shifts BE_BYTE0 by the low address bits
    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    // One queued write: word-aligned address, lane-replicated data, byte enables
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  byteen;
    } st_entry_t;

    function automatic logic is_store_op(input logic [3:0] op);
        return (op == LS_SW) || (op == LS_SH) || (op == LS_SB);
    endfunction

endpackage

// File: rtl/m_store_align.sv
// rtl/m_store_align.sv - store decode, byte-lane alignment and address-error check (M_STORE_ADES_EN enables AdES)
module m_store_align
    import ls_pkg::*;
(
    input  logic        en,
    input  logic [3:0]  ls_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        st,
    output logic        exc_ades,
    output st_entry_t   entry
);

    logic is_sw;
    logic is_sh;
    logic is_sb;

    // Opcode decode
    always_comb begin
        is_sw = (ls_op == LS_SW);
        is_sh = (ls_op == LS_SH);
        is_sb = (ls_op == LS_SB);
    end

`ifdef M_STORE_ADES_EN
    // Misaligned word/half stores fault and are dropped rather than queued
    assign exc_ades = en & ((is_sw & (addr[1:0] != 2'b00)) | (is_sh & addr[0]));
`else
    // Misalignment is tolerated: low address bits the access cannot use are ignored
    assign exc_ades = 1'b0;
`endif

    assign st = en & is_store_op(ls_op) & ~exc_ades;

    // Lane placement: data is replicated across lanes so byte enables alone pick the target bytes
    always_comb begin
        entry.addr   = {addr[31:2], 2'b00};
        entry.wdata  = wdata;
        entry.byteen = BE_WORD;
        if (is_sh) begin
            entry.wdata  = {2{wdata[15:0]}};
            entry.byteen = addr[1] ? BE_HALF_HI : BE_HALF_LO;
        end else if (is_sb) begin
            entry.wdata  = {4{wdata[7:0]}};
            entry.byteen = BE_BYTE0 << addr[1:0];
        end
    end

endmodule

// File: rtl/m_store_buf.sv
// rtl/m_store_buf.sv - M-stage store queue draining to the data bus over req/gnt (M_STORE_ADES_EN enables AdES)
module m_store_buf
    import ls_pkg::*;
#(
    parameter int DEPTH = 2
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en_M,
    input  logic [3:0]  lsOp_M,
    input  logic [31:0] addr_M,
    input  logic [31:0] writeData_M,
    output logic        stall_M,
    output logic        excAdES_M,
    output logic        sb_empty,
    output logic [31:0] m_data_addr,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    output logic        m_data_req,
    input  logic        m_data_gnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Queue occupancy view; derived from the count, never stored separately
    localparam logic [1:0] SB_EMPTY   = 2'b00;
    localparam logic [1:0] SB_PARTIAL = 2'b01;
    localparam logic [1:0] SB_FULL    = 2'b10;

    logic            st;
    logic            exc_ades;
    st_entry_t       new_entry;
    st_entry_t       head_entry;

    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    st_entry_t       mem_q [DEPTH];
    st_entry_t       mem_d [DEPTH];

    logic [1:0]      sb_state;
    logic            full;
    logic            push;
    logic            pop;

    m_store_align u_align (
        .en       (en_M),
        .ls_op    (lsOp_M),
        .addr     (addr_M),
        .wdata    (writeData_M),
        .st       (st),
        .exc_ades (exc_ades),
        .entry    (new_entry)
    );

    // Classify occupancy into empty / partial / full
    always_comb begin
        sb_state = SB_PARTIAL;
        if (count_q == '0) begin
            sb_state = SB_EMPTY;
        end else if (count_q == FULL_CNT) begin
            sb_state = SB_FULL;
        end
    end

    assign full       = (sb_state == SB_FULL);
    assign m_data_req = (sb_state != SB_EMPTY);
    assign sb_empty   = (sb_state == SB_EMPTY);

    // A store that meets a full queue stalls even if the head drains this cycle;
    // it is accepted on the following cycle when the count has actually dropped.
    assign push      = st & ~full;
    assign pop       = m_data_req & m_data_gnt;
    assign stall_M   = st & full;
    assign excAdES_M = exc_ades;

    // Bus side is driven purely from registered storage and pointers
    assign head_entry    = mem_q[head_q];
    assign m_data_addr   = head_entry.addr;
    assign m_data_wdata  = head_entry.wdata;
    assign m_data_byteen = head_entry.byteen;

    // Next-state for storage, pointers and count
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            mem_d[tail_q] = new_entry;
            tail_d        = tail_q + PW'(1);
        end
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue state; reset discards everything at once, dropping the request asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: tb/tb_m_store_buf.sv
// tb/tb_m_store_buf.sv - self-checking bench for m_store_buf (honours M_STORE_ADES_EN)
module tb_m_store_buf;
    import ls_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_M;
    logic [3:0]  lsOp_M;
    logic [31:0] addr_M;
    logic [31:0] writeData_M;
    logic        stall_M;
    logic        excAdES_M;
    logic        sb_empty;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic        m_data_req;
    logic        m_data_gnt;

    int n_tests = 0;
    int n_fail  = 0;

    st_entry_t model_q[$];

    always #5 clk = ~clk;

    m_store_buf #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .en_M          (en_M),
        .lsOp_M        (lsOp_M),
        .addr_M        (addr_M),
        .writeData_M   (writeData_M),
        .stall_M       (stall_M),
        .excAdES_M     (excAdES_M),
        .sb_empty      (sb_empty),
        .m_data_addr   (m_data_addr),
        .m_data_wdata  (m_data_wdata),
        .m_data_byteen (m_data_byteen),
        .m_data_req    (m_data_req),
        .m_data_gnt    (m_data_gnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic st_entry_t model_entry(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] wd);
        st_entry_t e;
        e.addr = a & 32'hFFFF_FFFC;
        if (op == LS_SW) begin
            e.wdata  = wd;
            e.byteen = 4'hF;
        end else if (op == LS_SH) begin
            e.wdata  = (wd & 32'h0000_FFFF) * 32'h0001_0001;
            e.byteen = ((a % 4) >= 2) ? 4'hC : 4'h3;
        end else begin
            e.wdata  = (wd & 32'h0000_00FF) * 32'h0101_0101;
            e.byteen = 4'(1 << (a % 4));
        end
        return e;
    endfunction

    function automatic logic model_exc(input logic en, input logic [3:0] op, input logic [31:0] a);
`ifdef M_STORE_ADES_EN
        return en && (((op == LS_SW) && (a % 4 != 0)) || ((op == LS_SH) && (a % 2 != 0)));
`else
        return 1'b0;
`endif
    endfunction

    // Per-cycle compare against the queue model, then advance the model to the next edge
    always @(negedge clk) begin
        logic      e_exc;
        logic      e_st;
        logic      do_pop;
        logic      do_push;
        st_entry_t h;
        if (reset === 1'b1) begin
            model_q.delete();
        end
        e_exc = model_exc(en_M, lsOp_M, addr_M);
        e_st  = en_M && (lsOp_M inside {LS_SW, LS_SH, LS_SB}) && !e_exc;
        check("req",      m_data_req, model_q.size() != 0);
        check("sb_empty", sb_empty,   model_q.size() == 0);
        check("exc",      excAdES_M,  e_exc);
        check("stall",    stall_M,    e_st && (model_q.size() == DEPTH));
        if (model_q.size() != 0) begin
            h = model_q[0];
            check("head_addr",   m_data_addr,   h.addr);
            check("head_wdata",  m_data_wdata,  h.wdata);
            check("head_byteen", m_data_byteen, h.byteen);
        end
        if (reset !== 1'b1) begin
            do_pop  = (model_q.size() != 0) && m_data_gnt;
            do_push = e_st && (model_q.size() < DEPTH);
            if (do_pop) begin
                void'(model_q.pop_front());
            end
            if (do_push) begin
                model_q.push_back(model_entry(lsOp_M, addr_M, writeData_M));
            end
        end
    end

    task automatic drive(input logic en, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input logic g);
        en_M        = en;
        lsOp_M      = op;
        addr_M      = a;
        writeData_M = wd;
        m_data_gnt  = g;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && !sb_empty; k++) begin
            drive(1'b0, LS_NONE, 32'h0, 32'h0, 1'b1);
            step();
        end
        check("drain_done", sb_empty, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, LS_NONE, 32'h0, 32'h0, 1'b0);
        step();
        check("rst_req",    m_data_req,    1'b0);
        check("rst_empty",  sb_empty,      1'b1);
        check("rst_addr",   m_data_addr,   32'h0);
        check("rst_wdata",  m_data_wdata,  32'h0);
        check("rst_byteen", m_data_byteen, 4'h0);
        check("rst_stall",  stall_M,       1'b0);
        reset = 1'b0;

        // sb to 0x1003, zero-wait grant
        drive(1'b1, LS_SB, 32'h0000_1003, 32'h0000_00AB, 1'b1);
        step();
        drive(1'b0, LS_NONE, 32'h0, 32'h0, 1'b1);
        check("sb_req",    m_data_req,    1'b1);
        check("sb_addr",   m_data_addr,   32'h0000_1000);
        check("sb_byteen", m_data_byteen, 4'b1000);
        check("sb_wdata",  m_data_wdata,  32'hABAB_ABAB);
        step();
        check("sb_done_empty", sb_empty, 1'b1);

        // sh + sw held without grant, then a third store stalls
        drive(1'b1, LS_SH, 32'h0000_2002, 32'h0000_1234, 1'b0);
        step();
        drive(1'b1, LS_SW, 32'h0000_2004, 32'hDEAD_BEEF, 1'b0);
        step();
        drive(1'b0, LS_NONE, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("hold_addr",   m_data_addr,   32'h0000_2000);
            check("hold_wdata",  m_data_wdata,  32'h1234_1234);
            check("hold_byteen", m_data_byteen, 4'b1100);
            step();
        end
        drive(1'b1, LS_SB, 32'h0000_2005, 32'h0000_0077, 1'b0);
        check("full_stall", stall_M, 1'b1);
        step();
        drive(1'b1, LS_SB, 32'h0000_2005, 32'h0000_0077, 1'b1);
        check("stall_with_gnt", stall_M, 1'b1);
        step();
        drive(1'b1, LS_SB, 32'h0000_2005, 32'h0000_0077, 1'b1);
        check("stall_released", stall_M, 1'b0);
        step();
        drive(1'b0, LS_NONE, 32'h0, 32'h0, 1'b1);
        check("pp_addr",   m_data_addr,   32'h0000_2004);
        check("pp_byteen", m_data_byteen, 4'b0010);
        check("pp_wdata",  m_data_wdata,  32'h7777_7777);
        check("pp_req",    m_data_req,    1'b1);
        step();
        drain();

        // Misaligned sw
        drive(1'b1, LS_SW, 32'h0000_3002, 32'hCAFE_F00D, 1'b0);
`ifdef M_STORE_ADES_EN
        check("ades_exc", excAdES_M, 1'b1);
        check("ades_stall", stall_M, 1'b0);
        step();
        drive(1'b0, LS_NONE, 32'h0, 32'h0, 1'b0);
        check("ades_nopush", sb_empty, 1'b1);
`else
        check("noades_exc", excAdES_M, 1'b0);
        step();
        drive(1'b0, LS_NONE, 32'h0, 32'h0, 1'b0);
        check("noades_addr",   m_data_addr,   32'h0000_3000);
        check("noades_byteen", m_data_byteen, 4'b1111);
        check("noades_wdata",  m_data_wdata,  32'hCAFE_F00D);
`endif
        drain();

        // Six back-to-back stores with a grant every cycle: count stays 1, pointers wrap
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, (i % 3 == 0) ? LS_SW : ((i % 3 == 1) ? LS_SH : LS_SB),
                  32'h0000_4000 + 32'(i * 5), 32'h1111_0000 + 32'(i * 32'h0101), 1'b1);
            check("wrap_nostall", stall_M, 1'b0);
            step();
        end
        drain();

        // Fill queue, then non-stores must neither stall nor push
        drive(1'b1, LS_SW, 32'h0000_5000, 32'h0000_0001, 1'b0);
        step();
        drive(1'b1, LS_SW, 32'h0000_5004, 32'h0000_0002, 1'b0);
        step();
        drive(1'b0, LS_SW, 32'h0000_5008, 32'h0000_0003, 1'b0);
        check("en0_stall", stall_M,   1'b0);
        check("en0_exc",   excAdES_M, 1'b0);
        step();
        drive(1'b1, LS_LW, 32'h0000_500A, 32'h0000_0004, 1'b0);
        check("lw_stall", stall_M,   1'b0);
        check("lw_exc",   excAdES_M, 1'b0);
        step();
        drive(1'b0, LS_NONE, 32'h0, 32'h0, 1'b0);
        check("full_head", m_data_addr, 32'h0000_5000);
        check("full_req",  m_data_req,  1'b1);

        // Reset mid-transfer with two entries pending
        #2;
        reset = 1'b1;
        #1;
        check("midrst_req",   m_data_req, 1'b0);
        check("midrst_empty", sb_empty,   1'b1);
        drive(1'b0, LS_NONE, 32'h0, 32'h0, 1'b1);
        step();
        reset = 1'b0;
        step();
        step();
        check("postrst_req",   m_data_req, 1'b0);
        check("postrst_empty", sb_empty,   1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/m_store_buf.md
# m_store_buf

Memory-stage store path: the write-side counterpart of the load extension unit. It decodes `sw`/`sh`/`sb`, aligns store data into byte lanes, generates byte enables, and queues the resulting word-aligned writes in a small FIFO. The FIFO drains to the data bus through a req/gnt handshake. The block asserts a pipeline stall when a store arrives and the queue is full.

## Interface
Parameters:
- `DEPTH`, 2: store queue entries; power of two, ≥2.

Ports (clk, reset first):
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `en_M`  in  1  M-stage instruction valid (low on bubble or flush).
- `lsOp_M`  in  4  load/store opcode; stores are `LS_SW`=4'b0110, `LS_SH`=4'b0111, `LS_SB`=4'b1000.
- `addr_M`  in  32  byte address.
- `writeData_M`  in  32  rt value to store.
- `stall_M`  out  1  freeze the pipeline at M; the store is not accepted this cycle.
- `excAdES_M`  out  1  store address error (see Configuration).
- `sb_empty`  out  1  queue empty and no bus request outstanding.
- `m_data_addr`  out  32  word-aligned write address, `{addr[31:2],2'b00}`.
- `m_data_wdata`  out  32  lane-replicated write data.
- `m_data_byteen`  out  4  byte enables.
- `m_data_req`  out  1  write request; high whenever the queue is non-empty.
- `m_data_gnt`  in  1  bus accepts the head entry this cycle.

## Operation
- Store request: `st = en_M & (lsOp_M ∈ {LS_SW,LS_SH,LS_SB}) & ~excAdES_M`.
- Lane alignment:
  - `sw`: byteen 4'b1111, data = `writeData_M`.
  - `sh`: byteen 4'b0011 if `addr[1]`=0, else 4'b1100; data = `{2{wd[15:0]}}`.
  - `sb`: byteen = 4'b0001 << `addr[1:0]`; data = `{4{wd[7:0]}}`.
- Push: `st & ~full` writes {addr, wdata, byteen} at the tail and increments the tail pointer.
- Pop: `m_data_req & m_data_gnt` increments the head pointer.
- Push and pop in the same cycle: both occur and the count is unchanged.
- `stall_M = st & full`. A pop in the same cycle does not clear the stall; the store is accepted on the next cycle.
- Count is `$clog2(DEPTH)+1` bits. Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH.
- Non-store opcodes, and `en_M`=0, never push, stall, or raise an exception.
- States are implied by count:
  - EMPTY (count 0): no request.
  - PARTIAL: request active, stores accepted.
  - FULL (count DEPTH): request active, new stores stall.
- FIFO ordering is strict; stores reach the bus in program order.

## Timing
- Reset: count, pointers, and all storage are 0. `m_data_req`=0, `m_data_addr`/`wdata`/`byteen`=0, `stall_M`=0, `sb_empty`=1.
- Bus outputs come from the registered head entry. There is no combinational path from M-stage inputs to `m_data_*`.
- Latency: a store pushed in cycle N into an empty queue gives `m_data_req`=1 in cycle N+1.
- Zero-wait grant: a grant in N+1 completes the store, so `sb_empty`=1 in N+2 if nothing else was pushed.
- While `m_data_req`=1 and `m_data_gnt`=0, `m_data_addr`/`wdata`/`byteen` stay stable.
- `m_data_gnt` while `m_data_req`=0 is ignored.
- `stall_M` and `excAdES_M` are combinational from M inputs and the current count, valid in the same cycle.
- Reset asserted mid-transfer: the queue is discarded immediately and the request drops asynchronously. Pending stores are lost.

## Configuration
- `M_STORE_ADES_EN` defined:
  - `excAdES_M` = `en_M & ((sw & addr[1:0]≠0) | (sh & addr[0]))`.
  - A faulting store is not pushed and does not stall.
- `M_STORE_ADES_EN` undefined:
  - `excAdES_M` is tied to 0.
  - Misaligned `sw` writes the enclosing word (low bits ignored).
  - Misaligned `sh` uses `addr[1]` only.

## Structure
- Shared package `ls_pkg`:
  - lsOp encodings `LS_LW`..`LS_LBU` (0001–0101) and `LS_SW`/`LS_SH`/`LS_SB`, shared with the load extension unit.
  - Byte-enable constants `BE_WORD`, `BE_HALF_LO`, `BE_HALF_HI`.
  - Struct `st_entry_t` {addr, wdata, byteen}.
- One combinational sub-module, `m_store_align`, covers opcode decode, lane/byteen generation and the AdES check. The FIFO and handshake live in the top module.

## Test plan
- Reset, then `sb` to 0x1003 with wd 0x000000AB, gnt=1 → next cycle req=1, addr 0x1000, byteen 4'b1000, wdata 0xABABABAB; the cycle after, `sb_empty`=1.
- `sh` to 0x2002 with wd 0x1234, then `sw` to 0x2004 with wd 0xDEADBEEF, gnt=0 for 3 cycles → head holds {0x2000, 0x12341234, 4'b1100} stable, count 2. A third store → `stall_M`=1 until the first gnt cycle has passed.
- Queue at count 1, `st` and `gnt` in the same cycle → count stays 1 and the new entry appears at head next cycle. Covers pointer wrap with DEPTH=2 over 6 stores.
- With `M_STORE_ADES_EN`: `sw` to 0x3002 → `excAdES_M`=1, no push, `sb_empty` remains 1. Without the macro: same stimulus → addr 0x3000, byteen 4'b1111.
- `en_M`=0 with `lsOp_M`=`LS_SW`, and `lsOp_M`=`LS_LW` with `en_M`=1 → no push, `stall_M`=0, `excAdES_M`=0.
- Reset asserted while req=1 and count=2 → req=0 and `sb_empty`=1 immediately; no grant is consumed after release.
